// File: rtl/acq_fifo_irq_ctrl.sv
// ADC sample sequencer feeding the PS data FIFO: capture gating, sample limit,
// mirrored FIFO level, level interrupt and overflow accounting.
module acq_fifo_irq_ctrl #(
  parameter int FIFO_DEPTH  = 1024,
  parameter int LVL_W       = 16,
  parameter bit SIGN_EXTEND = 1'b1
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cfg_enable,
  input  logic             cfg_irq_en,
  input  logic [LVL_W-1:0] cfg_threshold,
  input  logic [31:0]      cfg_sample_limit,
  input  logic             s_valid,
  input  logic [23:0]      s_data,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_wr_data,
  input  logic             fifo_rd_en,
  input  logic             ovf_clr,
  output logic [LVL_W-1:0] level,
  output logic             irq,
  output logic             ovf_sticky,
  output logic [15:0]      drop_cnt,
  output logic [31:0]      sample_cnt,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | capture disabled, waiting for cfg_enable
  // RUN   | accepting samples into the FIFO
  // DONE  | sample limit reached, waiting for cfg_enable to drop
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [LVL_W:0] DEPTH = (LVL_W+1)'(FIFO_DEPTH);

  state_t           state, state_nxt;
  logic             accept, drop, done_nxt, lim_hit, irq_nxt;
  logic [31:0]      cnt_nxt;
  logic [LVL_W:0]   occ;
  logic [LVL_W-1:0] level_nxt;
  logic [31:0]      ext_data;

  // Count and occupancy include the write already in flight so the limit and
  // the FIFO depth can never be overshot by the one-cycle write pipeline.
  assign cnt_nxt  = sample_cnt + {31'b0, fifo_wr_en};
  assign lim_hit  = (cfg_sample_limit != 32'd0) && (cnt_nxt >= cfg_sample_limit);
  assign occ      = {1'b0, level} + {{LVL_W{1'b0}}, fifo_wr_en};
  assign ext_data = SIGN_EXTEND ? {{8{s_data[23]}}, s_data} : {8'h00, s_data};
  assign busy     = (state == RUN);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    drop      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (cfg_enable) state_nxt = RUN;
      RUN: begin
        if (!cfg_enable) begin
          state_nxt = IDLE;
        end else if (lim_hit) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (s_valid) begin
          if (occ < DEPTH) accept = 1'b1;
          else             drop   = 1'b1;
        end
      end
      DONE: if (!cfg_enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = level;
    case ({fifo_wr_en, fifo_rd_en && (level != '0)})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
    irq_nxt = cfg_irq_en && (cfg_threshold != '0) && (level_nxt >= cfg_threshold);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= IDLE;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= 32'd0;
      level        <= '0;
      irq          <= 1'b0;
      ovf_sticky   <= 1'b0;
      drop_cnt     <= 16'd0;
      sample_cnt   <= 32'd0;
      done         <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_wr_en <= accept;
      if (accept) fifo_wr_data <= ext_data;
      level      <= level_nxt;
      irq        <= irq_nxt;
      done       <= done_nxt;
      if (state == IDLE && cfg_enable) sample_cnt <= 32'd0;
      else                             sample_cnt <= cnt_nxt;
      // A drop coincident with ovf_clr restarts the count at one.
      if (drop) begin
        ovf_sticky <= 1'b1;
        if (ovf_clr)                 drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
        drop_cnt   <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_acq_fifo_irq_ctrl.sv
// Directed self-checking bench for acq_fifo_irq_ctrl; inputs change and
// outputs are observed on the falling clock edge.
module tb_acq_fifo_irq_ctrl;

  logic        aclk;
  logic        areset;
  logic        cfg_enable;
  logic        cfg_irq_en;
  logic [15:0] cfg_threshold;
  logic [31:0] cfg_sample_limit;
  logic        s_valid;
  logic [23:0] s_data;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_rd_en;
  logic        ovf_clr;
  logic [15:0] level;
  logic        irq;
  logic        ovf_sticky;
  logic [15:0] drop_cnt;
  logic [31:0] sample_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int          wr_total = 0;
  logic [31:0] wlog [0:4095];

  acq_fifo_irq_ctrl #(.FIFO_DEPTH(1024), .LVL_W(16), .SIGN_EXTEND(1'b1)) dut (
    .aclk(aclk), .areset(areset), .cfg_enable(cfg_enable), .cfg_irq_en(cfg_irq_en),
    .cfg_threshold(cfg_threshold), .cfg_sample_limit(cfg_sample_limit),
    .s_valid(s_valid), .s_data(s_data), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_rd_en(fifo_rd_en), .ovf_clr(ovf_clr),
    .level(level), .irq(irq), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt),
    .sample_cnt(sample_cnt), .busy(busy), .done(done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Write log: every FIFO push seen on a rising edge.
  always @(posedge aclk) begin
    if (fifo_wr_en) begin
      if (wr_total < 4096) wlog[wr_total] <= fifo_wr_data;
      wr_total <= wr_total + 1;
    end
  end

  function automatic logic [23:0] gen(input int i);
    logic [31:0] v;
    v = i * 40503 + 123;
    gen = (i == 0) ? 24'h800000 : v[23:0];
  endfunction

  function automatic logic [31:0] sext(input logic [23:0] d);
    sext = {{8{d[23]}}, d};
  endfunction

  task automatic step();
    @(negedge aclk);
  endtask

  task automatic do_reset();
    areset = 1'b1; cfg_enable = 1'b0; cfg_irq_en = 1'b0; cfg_threshold = 16'd0;
    cfg_sample_limit = 32'd0; s_valid = 1'b0; s_data = 24'd0;
    fifo_rd_en = 1'b0; ovf_clr = 1'b0;
    step(); step();
    areset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [103:0] all;
    do_reset();
    all = {fifo_wr_en, fifo_wr_data, level, irq, ovf_sticky, drop_cnt, sample_cnt, busy, done};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all);
    end
  endtask

  task automatic test_irq_level();
    int base, bad;
    do_reset();
    cfg_threshold = 16'd512; cfg_irq_en = 1'b1; cfg_sample_limit = 32'd0; cfg_enable = 1'b1;
    step();
    base = wr_total;
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'b1; s_data = gen(i);
      step();
      if (wr_total - base == 511) begin
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_at_511: got %b expected 0", irq); end
      end
      if (wr_total - base == 512) begin
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_512: got %b expected 1", irq); end
      end
    end
    s_valid = 1'b0;
    step(); step();
    checks++;
    if (wr_total - base !== 600) begin errors++; $display("FAIL irq_writes: got %0d expected 600", wr_total - base); end
    checks++;
    if (level !== 16'd600) begin errors++; $display("FAIL irq_level600: got %0d expected 600", level); end
    checks++;
    if (wlog[base] !== 32'hFF800000) begin errors++; $display("FAIL first_data: got %h expected ff800000", wlog[base]); end
    bad = 0;
    for (int i = 0; i < 600; i++) if (wlog[base+i] !== sext(gen(i))) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL data_all: got %0d bad words expected 0", bad); end
    for (int r = 1; r <= 512; r++) begin
      fifo_rd_en = 1'b1;
      step();
      if (r == 88) begin
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_lvl512: got %b expected 1", irq); end
      end
      if (r == 89) begin
        checks++;
        if ({level, irq} !== {16'd511, 1'b0}) begin
          errors++; $display("FAIL irq_lvl511: got level %0d irq %b expected 511 0", level, irq);
        end
      end
    end
    fifo_rd_en = 1'b0;
    step();
    checks++;
    if (level !== 16'd88) begin errors++; $display("FAIL level88: got %0d expected 88", level); end
  endtask

  task automatic test_limit();
    int base, dones;
    do_reset();
    cfg_sample_limit = 32'd100; cfg_enable = 1'b1;
    step();
    base = wr_total; dones = 0;
    for (int i = 0; i < 130; i++) begin
      s_valid = 1'b1; s_data = gen(i);
      step();
      if (done === 1'b1) dones++;
    end
    s_valid = 1'b0;
    step();
    checks++;
    if (wr_total - base !== 100) begin errors++; $display("FAIL limit_writes: got %0d expected 100", wr_total - base); end
    checks++;
    if (dones !== 1) begin errors++; $display("FAIL limit_done_pulses: got %0d expected 1", dones); end
    checks++;
    if ({busy, sample_cnt, drop_cnt, ovf_sticky} !== {1'b0, 32'd100, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL limit_status: got busy %b cnt %0d drops %0d ovf %b expected 0 100 0 0",
               busy, sample_cnt, drop_cnt, ovf_sticky);
    end
    cfg_enable = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    cfg_enable = 1'b1;
    step();
    base = wr_total;
    for (int i = 0; i < 1030; i++) begin
      s_valid = 1'b1; s_data = gen(i);
      step();
    end
    s_valid = 1'b0;
    step(); step();
    checks++;
    if (wr_total - base !== 1024) begin errors++; $display("FAIL ovf_writes: got %0d expected 1024", wr_total - base); end
    checks++;
    if ({level, ovf_sticky, drop_cnt} !== {16'd1024, 1'b1, 16'd6}) begin
      errors++;
      $display("FAIL ovf_state: got level %0d ovf %b drops %0d expected 1024 1 6", level, ovf_sticky, drop_cnt);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    checks++;
    if ({ovf_sticky, drop_cnt} !== 17'd0) begin
      errors++; $display("FAIL ovf_clear: got ovf %b drops %0d expected 0 0", ovf_sticky, drop_cnt);
    end
    ovf_clr = 1'b1; s_valid = 1'b1;
    step();
    ovf_clr = 1'b0; s_valid = 1'b0;
    checks++;
    if ({ovf_sticky, drop_cnt} !== {1'b1, 16'd1}) begin
      errors++; $display("FAIL ovf_clr_drop: got ovf %b drops %0d expected 1 1", ovf_sticky, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    // Continues from the full FIFO left by the overflow test.
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    checks++;
    if (level !== 16'd1023) begin errors++; $display("FAIL b2b_pre: got %0d expected 1023", level); end
    base = wr_total;
    s_valid = 1'b1; s_data = 24'h123456;
    step();
    s_valid = 1'b0; fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    checks++;
    if ({level, 32'(wr_total - base)} !== {16'd1023, 32'd1}) begin
      errors++; $display("FAIL b2b_rw: got level %0d writes %0d expected 1023 1", level, wr_total - base);
    end
    checks++;
    if (wlog[base] !== 32'h00123456) begin errors++; $display("FAIL b2b_data: got %h expected 00123456", wlog[base]); end
    do_reset();
    fifo_rd_en = 1'b1;
    step(); step();
    fifo_rd_en = 1'b0;
    checks++;
    if (level !== 16'd0) begin errors++; $display("FAIL rd_empty: got %0d expected 0", level); end
  endtask

  task automatic test_enable_drop();
    int base;
    do_reset();
    cfg_enable = 1'b1;
    step();
    base = wr_total;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = gen(i);
      step();
    end
    cfg_enable = 1'b0; s_valid = 1'b1; s_data = 24'h0ABCDE;
    step();
    s_valid = 1'b0;
    step(); step();
    checks++;
    if ({32'(wr_total - base), busy, sample_cnt} !== {32'd10, 1'b0, 32'd10}) begin
      errors++;
      $display("FAIL en_drop: got writes %0d busy %b cnt %0d expected 10 0 10", wr_total - base, busy, sample_cnt);
    end
    cfg_enable = 1'b1;
    step();
    checks++;
    if ({busy, sample_cnt} !== {1'b1, 32'd0}) begin
      errors++; $display("FAIL reenable: got busy %b cnt %0d expected 1 0", busy, sample_cnt);
    end
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    checks++;
    if (sample_cnt !== 32'd1) begin errors++; $display("FAIL reenable_cnt: got %0d expected 1", sample_cnt); end
  endtask

  task automatic test_reset_mid_run();
    logic [103:0] all;
    do_reset();
    cfg_threshold = 16'd256; cfg_irq_en = 1'b1; cfg_enable = 1'b1;
    step();
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1; s_data = gen(i);
      step();
    end
    s_valid = 1'b0;
    step(); step();
    checks++;
    if ({level, irq} !== {16'd300, 1'b1}) begin
      errors++; $display("FAIL pre_reset: got level %0d irq %b expected 300 1", level, irq);
    end
    cfg_threshold = 16'd301;
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL thr_raise: got %b expected 0", irq); end
    cfg_threshold = 16'd300;
    step();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL thr_lower: got %b expected 1", irq); end
    s_valid = 1'b1; s_data = 24'h000001;
    step();
    s_valid = 1'b0; areset = 1'b1;
    step();
    all = {fifo_wr_en, fifo_wr_data, level, irq, ovf_sticky, drop_cnt, sample_cnt, busy, done};
    checks++;
    if (all !== '0) begin errors++; $display("FAIL mid_reset: got %h expected 0", all); end
    areset = 1'b0; cfg_enable = 1'b0;
    step();
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr: got %b expected 0", fifo_wr_en); end
  endtask

  initial begin
    test_reset();
    test_irq_level();
    test_limit();
    test_overflow();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acq_fifo_irq_ctrl.md
Name: acq_fifo_irq_ctrl

Overview:
- Sequences the ADC sample stream into the PS-readable data FIFO.
- Gates capture on software enable and applies an optional sample-count limit.
- Mirrors FIFO occupancy, raises the level interrupt consumed by the PS, and flags overflow.
- Sits between the ADS1675 receiver (24-bit samples, no backpressure) and the AXI4-Lite FIFO; its config inputs are driven by the FIFO's register bank.

Parameters:
- FIFO_DEPTH, 1024: entries in the downstream FIFO; power of two, at most 32768.
- LVL_W, 16: width of level and threshold, and must satisfy FIFO_DEPTH ≤ 2^LVL_W - 1.
- SIGN_EXTEND, 1: 1 = sign-extend 24 to 32 bits; 0 = zero-pad.

Ports:
- aclk  in  1  single clock; the whole block is on this clock.
- areset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  capture enable, level-sensitive.
- cfg_irq_en  in  1  interrupt enable (control register bit 0).
- cfg_threshold  in  LVL_W  IRQ level threshold; 0 = IRQ disabled.
- cfg_sample_limit  in  32  samples per acquisition; 0 = continuous.
- s_valid  in  1  one-cycle sample strobe from the ADC receiver.
- s_data  in  24  two's-complement sample.
- fifo_wr_en  out  1  FIFO push strobe.
- fifo_wr_data  out  32  FIFO push data.
- fifo_rd_en  in  1  FIFO pop strobe (PS read of the data register).
- ovf_clr  in  1  clears ovf_sticky and drop_cnt.
- level  out  LVL_W  mirrored FIFO occupancy.
- irq  out  1  level interrupt to the PS.
- ovf_sticky  out  1  set when a sample is dropped.
- drop_cnt  out  16  dropped-sample count; saturates at 0xFFFF.
- sample_cnt  out  32  samples accepted in the current acquisition.
- busy  out  1  high in state RUN.
- done  out  1  one-cycle pulse when the sample limit is reached.

Behaviour:
- Reset values: all outputs 0, state IDLE. The FIFO shares areset, so level is cleared to 0 together with the FIFO contents.
- FSM state IDLE:
  - cfg_enable=1 → RUN.
  - sample_cnt is cleared on this transition.
- FSM state RUN:
  - busy=1.
  - cfg_enable=0 → IDLE on the next cycle. An s_valid arriving in that same cycle is discarded and not counted.
  - When sample_cnt reaches a nonzero cfg_sample_limit → DONE, with done pulsed for one cycle on entry.
- FSM state DONE:
  - Samples are ignored; none are counted as drops.
  - cfg_enable=0 → IDLE.
  - Re-enabling requires passing through IDLE.
- Accept rule (RUN, s_valid=1):
  - Accept if level + fifo_wr_en < FIFO_DEPTH. A read in the same cycle is not credited.
  - On accept: fifo_wr_en=1 on the next cycle, with fifo_wr_data = sign-extended or zero-padded s_data; sample_cnt increments with that write.
  - Latency: 1 cycle from s_valid to fifo_wr_en.
  - On reject: no write, ovf_sticky=1, drop_cnt+1 (saturating). State stays RUN.
- Limit check: accepted samples never exceed cfg_sample_limit. The sample that makes sample_cnt equal the limit is written, and the FSM moves to DONE in the same cycle as that write.
- Level update, per cycle:
  - +1 when fifo_wr_en=1.
  - −1 when fifo_rd_en=1 and level>0.
  - Both in the same cycle: unchanged.
  - fifo_rd_en with level=0 is ignored; level never wraps.
- IRQ:
  - irq is registered as cfg_irq_en & (cfg_threshold≠0) & (level ≥ cfg_threshold), evaluated on the updated level. It is therefore a level interrupt that deasserts the cycle after a read drops level below the threshold.
  - A threshold change takes effect on the next cycle.
- ovf_clr:
  - Clears ovf_sticky and drop_cnt.
  - A drop in the same cycle wins: ovf_sticky=1, drop_cnt=1.
- Changing cfg_sample_limit during RUN:
  - The new value is compared immediately.
  - A limit ≤ the current sample_cnt (and nonzero) → DONE on the next cycle.
- Reset mid-acquisition: immediate return to IDLE, counters 0, and any pending write is cancelled.

Test Plan:
- Threshold 512, irq_en=1, limit 0, 600 samples with no reads → irq rises the cycle after the 512th write; 512 reads bring level to 88 and irq low by the cycle after the read that drops level to 511; data matches sign-extended stimulus (0x800000 → 0xFF800000).
- Limit 100, enable held high, continuous samples → exactly 100 writes; done pulses once; busy=0; sample_cnt=100; later samples ignored and drop_cnt=0.
- FIFO_DEPTH=1024, 1030 samples with no reads → level=1024, ovf_sticky=1, drop_cnt=6; ovf_clr → both 0; a drop coincident with ovf_clr → drop_cnt=1.
- Simultaneous fifo_rd_en and write at level 1023 → level stays 1023 and the sample is accepted; fifo_rd_en at level 0 → level stays 0.
- Deassert cfg_enable coincident with s_valid after 10 samples → no 11th write, state IDLE; re-enable → sample_cnt restarts at 0.
- areset asserted mid-RUN with level 300 and irq high → next cycle all outputs 0, no fifo_wr_en.
